// File: rtl/trap_seq_ctrl.sv
// Trap sequencing controller: prioritises exceptions/interrupts, drives the one-cycle
// trap-entry and MRET sequences. Optional WFI stall support: define TRAP_SEQ_WFI_EN.
module trap_seq_ctrl #(
  parameter int CAUSE_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [31:0]        pc_in,
  input  logic               instr_valid_in,
  input  logic               ill_instr_in,
  input  logic               misal_instr_in,
  input  logic               misal_load_in,
  input  logic               misal_store_in,
  input  logic               ecall_in,
  input  logic               ebreak_in,
  input  logic               mret_in,
  input  logic               wfi_in,
  input  logic               mie_in,
  input  logic               meie_in,
  input  logic               mtie_in,
  input  logic               msie_in,
  input  logic               meip_in,
  input  logic               mtip_in,
  input  logic               msip_in,
  output logic               set_epc_out,
  output logic [31:0]        epc_pc_out,
  output logic               set_cause_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               int_or_exc_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               instret_inc_out
);

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_MTVEC = 2'b01;
  localparam logic [1:0] PC_EPC   = 2'b10;
  localparam logic [1:0] PC_HOLD  = 2'b11;

`ifdef TRAP_SEQ_WFI_EN
  typedef enum logic [1:0] {OPERATING, TRAP_TAKEN, TRAP_RETURN, WFI_STALL} state_t;
`else
  typedef enum logic [1:0] {OPERATING, TRAP_TAKEN, TRAP_RETURN} state_t;
`endif

  state_t state;

  // Interrupt sources before the global mstatus.MIE gate; WFI wake-up ignores MIE.
  logic ext_pend, sw_pend, tmr_pend, any_pend;
  assign ext_pend = meie_in & meip_in;
  assign sw_pend  = msie_in & msip_in;
  assign tmr_pend = mtie_in & mtip_in;
  assign any_pend = ext_pend | sw_pend | tmr_pend;

  logic [CAUSE_W-1:0] irq_cause;
  logic [CAUSE_W-1:0] trap_cause;
  logic               trap_is_int;
  logic               trap_hit;

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    irq_cause = CAUSE_W'(7);
    if (ext_pend)     irq_cause = CAUSE_W'(11);
    else if (sw_pend) irq_cause = CAUSE_W'(3);

    trap_hit    = 1'b1;
    trap_is_int = 1'b0;
    trap_cause  = '0;
    if (misal_instr_in)        trap_cause = CAUSE_W'(0);
    else if (ill_instr_in)     trap_cause = CAUSE_W'(2);
    else if (ebreak_in)        trap_cause = CAUSE_W'(3);
    else if (misal_load_in)    trap_cause = CAUSE_W'(4);
    else if (misal_store_in)   trap_cause = CAUSE_W'(6);
    else if (ecall_in)         trap_cause = CAUSE_W'(11);
    else if (mie_in && any_pend) begin
      trap_cause  = irq_cause;
      trap_is_int = 1'b1;
    end else begin
      trap_hit = 1'b0;
    end
  end

`ifndef TRAP_SEQ_WFI_EN
  logic wfi_unused;
  assign wfi_unused = wfi_in;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous; epc/cause are plain registers and are cleared here too.
    if (rst_in) begin
      state           <= OPERATING;
      set_epc_out     <= 1'b0;
      epc_pc_out      <= '0;
      set_cause_out   <= 1'b0;
      cause_out       <= '0;
      int_or_exc_out  <= 1'b0;
      mie_clear_out   <= 1'b0;
      mie_set_out     <= 1'b0;
      pc_src_out      <= PC_SEQ;
      flush_out       <= 1'b0;
      instret_inc_out <= 1'b0;
    end else begin
      set_epc_out     <= 1'b0;
      set_cause_out   <= 1'b0;
      mie_clear_out   <= 1'b0;
      mie_set_out     <= 1'b0;
      pc_src_out      <= PC_SEQ;
      flush_out       <= 1'b0;
      instret_inc_out <= 1'b0;

      unique case (state)
        OPERATING: begin
          if (instr_valid_in) begin
            if (trap_hit) begin
              state          <= TRAP_TAKEN;
              epc_pc_out     <= pc_in;
              cause_out      <= trap_cause;
              int_or_exc_out <= trap_is_int;
              set_epc_out    <= 1'b1;
              set_cause_out  <= 1'b1;
              mie_clear_out  <= 1'b1;
              pc_src_out     <= PC_MTVEC;
              flush_out      <= 1'b1;
            end else if (mret_in) begin
              state           <= TRAP_RETURN;
              mie_set_out     <= 1'b1;
              pc_src_out      <= PC_EPC;
              flush_out       <= 1'b1;
              instret_inc_out <= 1'b1;
`ifdef TRAP_SEQ_WFI_EN
            end else if (wfi_in) begin
              state      <= WFI_STALL;
              pc_src_out <= PC_HOLD;
`endif
            end else begin
              instret_inc_out <= 1'b1;
            end
          end
        end
`ifdef TRAP_SEQ_WFI_EN
        WFI_STALL: begin
          if (!any_pend) begin
            pc_src_out <= PC_HOLD;
          end else if (mie_in) begin
            state          <= TRAP_TAKEN;
            epc_pc_out     <= pc_in;
            cause_out      <= irq_cause;
            int_or_exc_out <= 1'b1;
            set_epc_out    <= 1'b1;
            set_cause_out  <= 1'b1;
            mie_clear_out  <= 1'b1;
            pc_src_out     <= PC_MTVEC;
            flush_out      <= 1'b1;
          end else begin
            state           <= OPERATING;
            instret_inc_out <= 1'b1;
          end
        end
`endif
        default: state <= OPERATING;
      endcase
    end
  end

endmodule
